// File: rtl/adc_capture_playback.sv
// adc_capture_playback
//   Triggered capture of a fixed-length burst of 12-bit ADC samples into an
//   internal buffer, followed by continuous replay of that buffer to the
//   14-bit DAC data path until the next trigger.
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   ad1_in     12-bit offset-binary ADC sample (registered once, not synchronized)
//   key        raw push-button, active high, asynchronous
//   dac_data   14-bit sample to the DAC formatter (MIDSCALE when not valid)
//   dac_valid  high while dac_data carries buffer data
//   busy       high while capturing
//   done       one-cycle pulse when the capture completes
//
// State      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | after reset, outputs parked at MIDSCALE, waiting for trig
// S_CAPTURE  | writing one sample every DECIM cycles, trig ignored
// S_PLAYBACK | replaying the buffer in a loop, trig restarts capture

module adc_capture_playback #(
    parameter int          DEPTH_LOG2   = 10,
    parameter int          DECIM        = 1,
    parameter int          DEBOUNCE_CYC = 16,
    parameter logic [13:0] MIDSCALE     = 14'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] ad1_in,
    input  logic        key,
    output logic [13:0] dac_data,
    output logic        dac_valid,
    output logic        busy,
    output logic        done
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [7:0]            DECIM_LAST = 8'(DECIM - 1);
    localparam logic [15:0]           DB_MAX     = 16'(DEBOUNCE_CYC);
    localparam logic [DEPTH_LOG2-1:0] ADDR_LAST  = '1;
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_PLAYBACK
    } state_t;

    state_t                r_state;
    logic [11:0]           r_ad;
    logic                  r_key_meta;
    logic                  r_key_s;
    logic [15:0]           r_db_cnt;
    logic                  r_key_db_d;
    logic                  r_trig;
    logic [DEPTH_LOG2-1:0] r_wr_addr;
    logic [DEPTH_LOG2-1:0] r_rd_addr;
    logic [7:0]            r_dec_cnt;
    logic                  r_rd_vld;
    logic [13:0]           r_dac_data;
    logic                  r_dac_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [11:0]           r_mem [DEPTH];
    logic [11:0]           r_rd_data;

    logic w_key_db;
    logic w_dec_wrap;
    logic w_wr_en;

    assign w_key_db   = (r_db_cnt == DB_MAX);
    assign w_dec_wrap = (r_dec_cnt == DECIM_LAST);
    assign w_wr_en    = (r_state == S_CAPTURE) && (r_dec_cnt == 8'd0);

    // Input conditioning: ADC register, key synchronizer, saturating debounce,
    // and a registered rising-edge detect that produces trig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ad       <= '0;
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
            r_db_cnt   <= '0;
            r_key_db_d <= 1'b0;
            r_trig     <= 1'b0;
        end else begin
            r_ad       <= ad1_in;
            r_key_meta <= key;
            r_key_s    <= r_key_meta;
            if (!r_key_s)
                r_db_cnt <= '0;
            else if (r_db_cnt != DB_MAX)
                r_db_cnt <= r_db_cnt + 16'd1;
            r_key_db_d <= w_key_db;
            r_trig     <= w_key_db & ~r_key_db_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_dec_cnt   <= '0;
            r_rd_vld    <= 1'b0;
            r_dac_data  <= MIDSCALE;
            r_dac_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_dac_valid <= 1'b0;
            r_dac_data  <= MIDSCALE;
            r_dec_cnt   <= w_dec_wrap ? 8'd0 : r_dec_cnt + 8'd1;
            case (r_state)
                S_IDLE: begin
                    if (r_trig) begin
                        r_state   <= S_CAPTURE;
                        r_busy    <= 1'b1;
                        r_wr_addr <= '0;
                        r_dec_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_wr_en) begin
                        if (r_wr_addr == ADDR_LAST) begin
                            r_state   <= S_PLAYBACK;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_rd_addr <= '0;
                            r_dec_cnt <= '0;
                        end else begin
                            r_wr_addr <= r_wr_addr + ADDR_ONE;
                        end
                    end
                end
                S_PLAYBACK: begin
                    if (r_trig) begin
                        r_state   <= S_CAPTURE;
                        r_busy    <= 1'b1;
                        r_wr_addr <= '0;
                        r_dec_cnt <= '0;
                    end else begin
                        // r_rd_vld marks that the RAM output already reflects a
                        // playback address, hiding the first cycle of read latency.
                        r_rd_vld    <= 1'b1;
                        r_dac_valid <= r_rd_vld;
                        r_dac_data  <= r_rd_vld ? {r_rd_data, 2'b00} : MIDSCALE;
                        if (w_dec_wrap)
                            r_rd_addr <= r_rd_addr + ADDR_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sample buffer: contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_addr] <= r_ad;
        r_rd_data <= r_mem[r_rd_addr];
    end

    assign dac_data  = r_dac_data;
    assign dac_valid = r_dac_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/adc_capture_playback.md
# adc_capture_playback

Triggered sample capture and playback stage between the 12-bit ADC input and the 14-bit DAC output path. A debounced push-button trigger records a fixed-length burst of ADC samples into an internal buffer. The buffer is then replayed continuously to the DAC data bus until the next trigger. The block sits directly downstream of the ADC pins and feeds the DAC formatter that drives DataA/ClkA/WRTA.

## Interface

Parameters:
- DEPTH_LOG2, 10: buffer depth is 2^DEPTH_LOG2 samples.
- DECIM, 1: write/read one sample every DECIM clocks. Legal range 1..255.
- DEBOUNCE_CYC, 16: consecutive synchronized-high cycles required on key. Legal range 1..65535.
- MIDSCALE, 14'h2000: DAC code driven while no playback data is valid.

Ports:
- clk, input, 1: single system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ad1_in, input, 12: ADC sample, offset binary, asynchronous to clk.
- key, input, 1: raw push-button, active high, asynchronous.
- dac_data, output, 14: playback sample to the DAC formatter.
- dac_valid, output, 1: high when dac_data carries buffer data.
- busy, output, 1: high while in CAPTURE.
- done, output, 1: one-cycle pulse when capture completes.

## Operation

Input conditioning:
- ad1_in is registered once into ad_r; there is no further synchronization.
- key passes through a 2-flop synchronizer, giving key_s.
- The debounce counter increments while key_s=1 and saturates at DEBOUNCE_CYC. It clears to 0 on any cycle with key_s=0.
- key_db=1 while the counter equals DEBOUNCE_CYC. trig is a one-cycle pulse on the rising edge of key_db.

States: IDLE, CAPTURE, PLAYBACK.
- IDLE:
  - dac_data=MIDSCALE, dac_valid=0.
  - trig -> CAPTURE.
- CAPTURE:
  - On entry, wr_addr=0 and the decimation counter is 0.
  - On each cycle where the decimation counter is 0, write ad_r to mem[wr_addr] and increment wr_addr.
  - The decimation counter counts 0..DECIM-1 and wraps.
  - After the write to address 2^DEPTH_LOG2-1: pulse done and go to PLAYBACK.
  - trig is ignored in this state.
  - busy=1.
- PLAYBACK:
  - On entry, rd_addr=0.
  - rd_addr advances once every DECIM cycles and wraps from 2^DEPTH_LOG2-1 to 0 indefinitely.
  - dac_data = {mem[rd_addr], 2'b00}, i.e. the 12-bit sample left-justified in 14 bits.
  - trig -> CAPTURE. dac_valid drops to 0 and dac_data=MIDSCALE in the cycle CAPTURE is entered.
- Buffer: single-port-write / single-port-read synchronous RAM, 12 bits wide, 1-cycle read latency. Contents are not cleared by reset.

## Timing

- Reset values: state=IDLE, dac_data=MIDSCALE, dac_valid=0, busy=0, done=0, all counters and addresses 0, synchronizer flops 0.
- Reset assertion mid-capture or mid-playback forces the reset values immediately (asynchronously). Only a new trig resumes operation.
- Trigger latency:
  - key high continuously from clock edge E0 gives trig on cycle E0+DEBOUNCE_CYC+2.
  - State=CAPTURE and busy=1 on the following cycle.
- Capture alignment: mem[0] holds ad1_in as sampled at the edge that registered trig.
- Capture duration: busy high for exactly DECIM*2^DEPTH_LOG2 - (DECIM-1) cycles. done pulses on the cycle after the final write, coincident with entry to PLAYBACK.
- Playback latency: the first dac_valid=1, carrying mem[0], appears 2 cycles after entry to PLAYBACK (1 RAM read + 1 output register). Each sample is then held for DECIM cycles.
- While dac_valid=1, dac_valid stays high continuously until a trig or reset.
- A key still held at the end of capture does not retrigger. A new trig needs key_db to fall and then rise again.

## Test plan

- Reset: hold rst_n=0 with key toggling -> dac_data=14'h2000, dac_valid=0, busy=0, done=0 throughout. After release there is no trig.
- Glitch rejection (DEBOUNCE_CYC=16): pulse key high for 10 cycles -> no busy. Hold key for 50 cycles -> busy rises exactly 19 cycles after the first sampled-high edge.
- Ramp capture (DEPTH_LOG2=4, DECIM=1):
  - Stimulus: ad1_in = cycle count starting at 12'h100 on the trig edge.
  - busy stays high for 16 cycles, then done pulses.
  - Playback dac_data = 14'h0400, 14'h0404, … 14'h043C, then wraps back to 14'h0400.
- Decimation (DECIM=4, ramp input): the captured values step by 4. Each dac_data value is held for 4 cycles.
- Retrigger: key pressed during CAPTURE -> ignored, capture length unchanged. Key pressed during PLAYBACK -> dac_valid=0 and dac_data=14'h2000, followed by a fresh capture.
- Reset mid-capture: assert rst_n=0 at wr_addr=7 -> outputs go to their reset values asynchronously. The block stays in IDLE until the next key press.
